prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//   Byte-stream program loader upstream of the fetch stage. Receives a program over a
//   valid/ready byte interface, assembles 9-bit instruction words and writes them into
//   the writable instruction memory. Holds the CPU (set_pc) while loading; releases it when done.
// PARAMETERS
//   INS_W   9   instruction word width
//   ADDR_W  4   instruction memory address width
//   DEPTH   16  instruction memory entries (2**ADDR_W)
// PORTS
//   clk      in   1       clock; all state updates on posedge
//   rst      in   1       asynchronous, active-high reset
//   start    in   1       begin a load; honoured in IDLE, DONE and ERR only
//   in_valid in   1       IN_DATA valid
//   in_ready out  1       loader accepts a byte this cycle
//   IN_DATA  in   8       program byte
//   wr_en    out  1       instruction memory write strobe, 1-cycle pulse
//   WR_ADDR  out  ADDR_W  write address
//   WR_INS   out  INS_W   write data
//   set_pc   out  1       1 = hold CPU PC at 0; drives the pc set_pc input
//   done     out  1       load completed successfully (level)
//   err      out  1       load aborted on a format error (level)
// BEHAVIOUR
//   - Byte accepted iff in_valid && in_ready in the same cycle. in_ready is a registered
//     function of state: 1 in CNT/LO/HI/CHK, 0 elsewhere.
//   - Reset values: in_ready=0, wr_en=0, WR_ADDR=0, WR_INS=0, set_pc=1, done=0, err=0.
//     State = IDLE, word counter = 0, count = 0. Instruction memory contents are not cleared.
//   - Stream format: count byte N; then N words as {lo, hi} byte pairs; then CHK byte if enabled.
//     Count byte: bits[3:0] = N, with 0 meaning DEPTH. bits[7:4] != 0 -> ERR.
//     Word: lo = INS[7:0]; hi bit0 = INS[8]. hi bits[7:1] != 0 -> ERR.
//   - FSM:
//     IDLE -start-> CNT.
//     CNT -byte ok-> LO.
//     LO -byte-> HI.
//     HI -byte ok-> LO, or CHK/DONE after word N.
//     CHK -byte-> DONE or ERR.
//     DONE/ERR -start-> CNT.
//   - Write: the cycle after an accepted valid hi byte, wr_en=1, WR_ADDR=word index
//     (0..N-1), WR_INS=assembled word. The word counter increments at the same time.
//     Latency: hi byte to write = 1 cycle. WR_ADDR/WR_INS hold their last value when wr_en=0.
//   - set_pc=1 in all states except DONE. It falls on the entry into DONE, in the same
//     cycle as or after the final wr_en, so the CPU never fetches a half-written program.
//   - done=1 only in DONE. err=1 only in ERR. Both clear on the cycle start is taken.
//   - start while in CNT/LO/HI/CHK is ignored. Loading continues.
//   - Word counter wrap: N=0 (DEPTH) writes addresses 0..15. The counter never exceeds N-1.
//   - A hi byte with bad bits produces no write for that word. Earlier writes persist.
//   - in_valid held with in_ready=0 has no effect. Bytes are neither consumed nor buffered.
//   - rst asserted mid-load: immediate return to reset values. set_pc is asserted
//     asynchronously. A partially loaded memory remains.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - After word N, state CHK expects a byte equal to the XOR of all preceding
//       bytes (count byte included).
//     - Match -> DONE; mismatch -> ERR. Memory writes are already committed.
//     - in_ready=1 in CHK.
//   LOADER_CHECKSUM_EN undefined:
//     - No CHK state. The final valid hi byte goes straight to DONE.
//     - No checksum register is instantiated.
// TESTING
//   1. rst=1, then release -> set_pc=1, in_ready=0, done=0, err=0, wr_en=0 until start.
//   2. start, bytes 02,34,01,A5,00 (+chk 92 if EN)
//      -> wr_en pulses: (0,0x134), (1,0x0A5); then done=1, set_pc=0.
//   3. Count byte 00 followed by 16 words
//      -> WR_ADDR 0..15 written in order; no 17th write; done=1.
//   4. Count byte 01, lo 12, hi 02 -> no write, err=1, set_pc=1.
//      start, then a valid stream -> err clears, load succeeds.
//   5. in_valid toggled 1/0 every cycle and start pulsed mid-load
//      -> same writes as the steady stream; start is ignored.
//   6. rst pulsed between lo and hi of word 1 -> outputs at reset values next cycle.
//      A fresh load writes from address 0.
//      (EN) wrong checksum byte -> err=1, done=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream loader bus: upstream byte handshake plus instruction-memory write port and CPU hold/status.
// master = byte source / status observer; slave = the loader.
interface prog_loader_if #(
    parameter int INS_W  = 9,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        IN_DATA;
    logic              wr_en;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [INS_W-1:0]  WR_INS;
    logic              set_pc;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, IN_DATA,
        input  in_ready, wr_en, WR_ADDR, WR_INS, set_pc, done, err
    );

    modport slave (
        input  start, in_valid, IN_DATA,
        output in_ready, wr_en, WR_ADDR, WR_INS, set_pc, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles {lo,hi} byte pairs into words, writes them 1 cycle after the hi byte,
// holds the CPU (set_pc) until DONE. Optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int INS_W  = 9,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_LO, S_HI, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [INS_W-1:0]    wr_ins_q, wr_ins_d;
    logic                set_pc_q, set_pc_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   last_q, last_d;   // N-1
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [7:0]          lo_q, lo_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic       acc;
    logic [7:0] din;

    assign acc = bus.in_valid && in_ready_q;
    assign din = bus.IN_DATA;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_ins_d  = wr_ins_q;
        last_d    = last_q;
        widx_d    = widx_q;
        lo_d      = lo_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_CNT;
                    widx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            S_CNT: if (acc) begin
                if (din[7:4] != 4'h0) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LO;
                    last_d  = (din[3:0] == 4'h0) ? ADDR_W'(DEPTH - 1)
                                                 : ADDR_W'(din[3:0]) - ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ din;
`endif
                end
            end
            S_LO: if (acc) begin
                state_d = S_HI;
                lo_d    = din;
`ifdef LOADER_CHECKSUM_EN
                chk_d   = chk_q ^ din;
`endif
            end
            S_HI: if (acc) begin
                if (din[7:1] != 7'h0) begin
                    state_d = S_ERR;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = widx_q;
                    wr_ins_d  = {din[0], lo_q};
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = chk_q ^ din;
`endif
                    // Counter parks on N-1 after the last word rather than wrapping.
                    if (widx_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_LO;
                        widx_d  = widx_q + ADDR_W'(1);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (acc) state_d = (din == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d = (state_d == S_CNT) || (state_d == S_LO) ||
                     (state_d == S_HI)  || (state_d == S_CHK);
        set_pc_d   = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_ins_q   <= '0;
            set_pc_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= '0;
            widx_q     <= '0;
            lo_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_ins_q   <= wr_ins_d;
            set_pc_q   <= set_pc_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_q     <= last_d;
            widx_q     <= widx_d;
            lo_q       <= lo_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.WR_ADDR  = wr_addr_q;
    assign bus.WR_INS   = wr_ins_q;
    assign bus.set_pc   = set_pc_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
